// File: rtl/mfcc_mel_filter_acc.sv
// Mel-filterbank accumulator for one MFCC filter channel.
// Streams FFT-bin powers, addresses the mel-weight ROM with the bin index,
// multiplies each power by the returned weight and emits one saturating
// accumulated energy per frame. Three-edge datapath: accept/ROM read,
// multiply, accumulate. Backpressure lives only on pwr_ready, so the
// pipeline itself never stalls.
module mfcc_mel_filter_acc #(
  parameter int ADDR_WIDTH = 9,
  parameter int COEF_WIDTH = 8,
  parameter int PWR_WIDTH  = 32,
  parameter int ACC_WIDTH  = PWR_WIDTH + COEF_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk_tb,
  input  logic                  tb_rst,
  input  logic                  pwr_valid,
  input  logic [PWR_WIDTH-1:0]  pwr_data,
  input  logic                  pwr_last,
  output logic                  pwr_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [COEF_WIDTH-1:0] rom_rd_data,
  output logic                  mel_valid,
  output logic [ACC_WIDTH-1:0]  mel_data,
  input  logic                  mel_ready,
  output logic                  frame_err,
  output logic                  ovf_err
);
  localparam int STAGES = 2;
  localparam int PROD_W = PWR_WIDTH + COEF_WIDTH;
  // Sum is wide enough for both operands plus a carry, so saturation is
  // detected correctly even when ACC_WIDTH is narrower than the product.
  localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
  localparam logic [ADDR_WIDTH-1:0] K_LAST  = '1;
  localparam logic [SUM_W-1:0]      ACC_MAX = {{(SUM_W-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, HOLD = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  k_q, k_d;
  logic                   accept, close_beat, len_err;
  logic [STAGES:1]        vld_pipe_q, close_pipe_q;
  logic [PWR_WIDTH-1:0]   s1_pwr_q;
  logic [PROD_W-1:0]      s2_prod_q, product;
  logic [ACC_WIDTH-1:0]   acc_q, mel_data_q, acc_next;
  logic [SUM_W-1:0]       sum;
  logic                   sat;
  logic                   frame_err_q, ovf_err_q;

  assign pwr_ready  = (state_q == RUN);
  assign mel_valid  = (state_q == HOLD);
  assign accept     = pwr_valid && pwr_ready;
  // Frame closes on pwr_last or when the bin counter is at its last index.
  assign close_beat = pwr_last || (k_q == K_LAST);
  // Short frame (last early) or long frame (no last at final bin).
  assign len_err    = pwr_last ^ (k_q == K_LAST);
  assign k_d        = close_beat ? '0 : k_q + 1'b1;
  assign rom_addr   = k_q;
  assign product    = PROD_W'(s1_pwr_q) * PROD_W'(rom_rd_data);
  assign sum        = SUM_W'(acc_q) + SUM_W'(s2_prod_q);
  assign sat        = (sum > ACC_MAX);
  assign acc_next   = sat ? '1 : sum[ACC_WIDTH-1:0];
  assign mel_data   = mel_data_q;
  assign frame_err  = frame_err_q;
  assign ovf_err    = ovf_err_q;

  // Frame-control state register.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state: close accepted -> drain pipeline -> hold result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && close_beat) state_d = FLUSH;
      FLUSH:   if (vld_pipe_q[STAGES] && close_pipe_q[STAGES]) state_d = HOLD;
      HOLD:    if (mel_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Front end: bin counter, length check, stage 1 and stage 2 registers.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      k_q          <= '0;
      frame_err_q  <= 1'b0;
      vld_pipe_q   <= '0;
      close_pipe_q <= '0;
      s1_pwr_q     <= '0;
      s2_prod_q    <= '0;
    end else begin
      vld_pipe_q   <= {vld_pipe_q[STAGES-1:1], accept};
      close_pipe_q <= {close_pipe_q[STAGES-1:1], accept && close_beat};
      if (accept) begin
        k_q      <= k_d;
        s1_pwr_q <= pwr_data;
        if (len_err) frame_err_q <= 1'b1;
      end
      if (vld_pipe_q[1]) s2_prod_q <= product;
    end
  end

  // Accumulator: saturating add, closing beat publishes and clears.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      acc_q      <= '0;
      mel_data_q <= '0;
      ovf_err_q  <= 1'b0;
    end else if (vld_pipe_q[STAGES]) begin
      if (sat) ovf_err_q <= 1'b1;
      if (close_pipe_q[STAGES]) begin
        mel_data_q <= acc_next;
        acc_q      <= '0;
      end else begin
        acc_q <= acc_next;
      end
    end
  end
endmodule

// File: tb/tb_mfcc_mel_filter_acc.sv
// Bench for mfcc_mel_filter_acc: behavioural 1-cycle ROM, per-scenario
// tasks, expected frame energies queued as beats are driven. A second,
// 16-bit-accumulator instance shares the stimulus for the saturation case.
module tb_mfcc_mel_filter_acc;
  logic        clk_tb = 1'b0;
  logic        tb_rst = 1'b1;
  logic        pwr_valid = 1'b0;
  logic [31:0] pwr_data = '0;
  logic        pwr_last = 1'b0;
  logic        mel_ready = 1'b1;

  logic        pwr_ready, mel_valid, frame_err, ovf_err;
  logic [8:0]  rom_addr;
  logic [48:0] mel_data;
  logic [7:0]  rom_q;

  logic        s_pwr_ready, s_mel_valid, s_frame_err, s_ovf_err;
  logic [8:0]  s_rom_addr;
  logic [15:0] s_mel_data;
  logic [7:0]  s_rom_q;

  int errors = 0;
  int checks = 0;
  int wmode  = 0;
  int pmode  = 0;
  longint unsigned exp_q[$];

  always #5 clk_tb = ~clk_tb;

  mfcc_mel_filter_acc dut (
    .clk_tb(clk_tb), .tb_rst(tb_rst),
    .pwr_valid(pwr_valid), .pwr_data(pwr_data), .pwr_last(pwr_last), .pwr_ready(pwr_ready),
    .rom_addr(rom_addr), .rom_rd_data(rom_q),
    .mel_valid(mel_valid), .mel_data(mel_data), .mel_ready(mel_ready),
    .frame_err(frame_err), .ovf_err(ovf_err)
  );

  mfcc_mel_filter_acc #(.ACC_WIDTH(16)) dut16 (
    .clk_tb(clk_tb), .tb_rst(tb_rst),
    .pwr_valid(pwr_valid), .pwr_data(pwr_data), .pwr_last(pwr_last), .pwr_ready(s_pwr_ready),
    .rom_addr(s_rom_addr), .rom_rd_data(s_rom_q),
    .mel_valid(s_mel_valid), .mel_data(s_mel_data), .mel_ready(mel_ready),
    .frame_err(s_frame_err), .ovf_err(s_ovf_err)
  );

  function automatic logic [7:0] wfn(input logic [8:0] a);
    case (wmode)
      0:       return a[7:0];
      1:       return 8'd2;
      2:       return 8'd1;
      default: return 8'd255;
    endcase
  endfunction

  function automatic logic [31:0] pfn(input int k);
    case (pmode)
      0:       return 32'd1;
      1:       return 32'(k);
      2:       return 32'd3;
      default: return 32'h0000_FFFF;
    endcase
  endfunction

  // Behavioural ROMs, one-cycle read latency.
  always @(posedge clk_tb) begin
    rom_q   <= wfn(rom_addr);
    s_rom_q <= wfn(s_rom_addr);
  end

  // Watchdog: guarantees termination even if a handshake never happens.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    @(negedge clk_tb);
    pwr_valid = 1'b0; pwr_last = 1'b0; tb_rst = 1'b1;
    exp_q.delete();
    @(negedge clk_tb);
    tb_rst = 1'b0;
  endtask

  // Drive n beats starting at bin 0; last asserted on the final beat if asked.
  task automatic send_frame(input int n, input bit last_flag, input bit rnd, input bit push);
    longint unsigned acc = 0;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk_tb);
          checks++;
          if (rom_addr !== 9'(i)) begin
            errors++; $display("FAIL rom_addr_gap: got %0d want %0d", rom_addr, i);
          end
        end
      end
      @(negedge clk_tb);
      checks++;
      if (rom_addr !== 9'(i) || pwr_ready !== 1'b1) begin
        errors++; $display("FAIL beat_addr: rom_addr=%0d pwr_ready=%b want %0d/1", rom_addr, pwr_ready, i);
      end
      pwr_valid = 1'b1;
      pwr_data  = pfn(i);
      pwr_last  = last_flag && (i == n - 1);
      acc += longint'(pfn(i)) * longint'(wfn(9'(i)));
      @(posedge clk_tb);
      #1;
      pwr_valid = 1'b0;
      pwr_last  = 1'b0;
    end
    if (push) exp_q.push_back(acc);
  endtask

  // Called right after the closing accept edge (+1).
  task automatic wait_result(input string name, input bit chk_lat);
    int cnt = 0;
    longint unsigned exp;
    checks++;
    if (pwr_ready !== 1'b0) begin
      errors++; $display("FAIL %s_ready_low: got %b want 0", name, pwr_ready);
    end
    while (mel_valid !== 1'b1 && cnt < 10) begin
      @(posedge clk_tb); #1; cnt++;
    end
    checks++;
    if (mel_valid !== 1'b1) begin
      errors++; $display("FAIL %s_timeout: mel_valid never rose", name);
    end else if (chk_lat && cnt != 2) begin
      errors++; $display("FAIL %s_latency: got %0d edges want 2", name, cnt);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s_queue: no expected value", name);
    end else begin
      exp = exp_q.pop_front();
      if (mel_data !== exp[48:0]) begin
        errors++; $display("FAIL %s_data: got %0d want %0d", name, mel_data, exp);
      end
    end
    if (mel_ready) begin
      @(posedge clk_tb); #1;
      checks++;
      if (mel_valid !== 1'b0 || pwr_ready !== 1'b1) begin
        errors++; $display("FAIL %s_handshake: mel_valid=%b pwr_ready=%b want 0/1", name, mel_valid, pwr_ready);
      end
    end
  endtask

  task automatic test_reset();
    tb_rst = 1'b1;
    repeat (2) @(negedge clk_tb);
    checks++;
    if (pwr_ready !== 1'b1 || rom_addr !== 9'd0 || mel_valid !== 1'b0 || mel_data !== 49'd0 ||
        frame_err !== 1'b0 || ovf_err !== 1'b0 || s_ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b addr=%0d mv=%b md=%0d fe=%b oe=%b s_oe=%b want 1/0/0/0/0/0/0",
               pwr_ready, rom_addr, mel_valid, mel_data, frame_err, ovf_err, s_ovf_err);
    end
    tb_rst = 1'b0;
  endtask

  task automatic test_full_frame();
    wmode = 0; pmode = 0; mel_ready = 1'b1;
    send_frame(512, 1'b1, 1'b0, 1'b1);
    wait_result("full", 1'b1);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL full_frame_err: got %b want 0", frame_err);
    end
  endtask

  task automatic test_random_gaps();
    wmode = 1; pmode = 1;
    send_frame(512, 1'b1, 1'b1, 1'b1);
    wait_result("gaps", 1'b1);
  endtask

  task automatic test_back_to_back();
    wmode = 0; pmode = 0; mel_ready = 1'b0;
    send_frame(512, 1'b1, 1'b0, 1'b1);
    wait_result("bp_first", 1'b1);
    repeat (20) begin
      @(posedge clk_tb); #1;
      checks++;
      if (mel_valid !== 1'b1 || mel_data !== 49'd65280 || pwr_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold: mv=%b md=%0d rdy=%b want 1/65280/0", mel_valid, mel_data, pwr_ready);
      end
    end
    @(negedge clk_tb);
    mel_ready = 1'b1;
    @(posedge clk_tb); #1;
    checks++;
    if (mel_valid !== 1'b0 || pwr_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: mv=%b rdy=%b want 0/1", mel_valid, pwr_ready);
    end
    wmode = 2; pmode = 2;
    send_frame(512, 1'b1, 1'b0, 1'b1);
    wait_result("bp_second", 1'b1);
  endtask

  task automatic test_frame_length();
    reset_dut();
    wmode = 2; pmode = 0;
    send_frame(100, 1'b1, 1'b0, 1'b1);
    wait_result("short", 1'b1);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL short_err: got %b want 1", frame_err);
    end
    reset_dut();
    send_frame(512, 1'b0, 1'b0, 1'b1);
    wait_result("long", 1'b1);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL long_err: got %b want 1", frame_err);
    end
    send_frame(4, 1'b1, 1'b0, 1'b1);
    wait_result("after_long", 1'b1);
  endtask

  task automatic test_overflow();
    reset_dut();
    wmode = 3; pmode = 3;
    send_frame(2, 1'b1, 1'b0, 1'b1);
    wait_result("ovf_wide", 1'b1);
    checks++;
    if (s_mel_data !== 16'hFFFF || s_ovf_err !== 1'b1) begin
      errors++; $display("FAIL ovf_narrow: md=%h oe=%b want ffff/1", s_mel_data, s_ovf_err);
    end
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++; $display("FAIL ovf_wide_flag: got %b want 0", ovf_err);
    end
  endtask

  task automatic test_reset_midframe();
    wmode = 0; pmode = 0;
    send_frame(200, 1'b0, 1'b0, 1'b0);
    @(negedge clk_tb);
    checks++;
    if (rom_addr !== 9'd200) begin
      errors++; $display("FAIL mid_addr: got %0d want 200", rom_addr);
    end
    tb_rst = 1'b1;
    #1;
    checks++;
    if (pwr_ready !== 1'b1 || rom_addr !== 9'd0 || mel_valid !== 1'b0 || mel_data !== 49'd0 ||
        frame_err !== 1'b0 || ovf_err !== 1'b0 || s_ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b addr=%0d mv=%b md=%0d fe=%b oe=%b s_oe=%b want 1/0/0/0/0/0/0",
               pwr_ready, rom_addr, mel_valid, mel_data, frame_err, ovf_err, s_ovf_err);
    end
    exp_q.delete();
    @(negedge clk_tb);
    tb_rst = 1'b0;
    send_frame(512, 1'b1, 1'b0, 1'b1);
    wait_result("post_reset", 1'b1);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL post_reset_err: got %b want 0", frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_gaps();
    test_back_to_back();
    test_frame_length();
    test_overflow();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mfcc_mel_filter_acc.md
# mfcc_mel_filter_acc

Mel-filterbank accumulator for one MFCC filter channel. It sits directly downstream of the per-filter mel-weight ROM (512 × 8-bit, e.g. MFCC_melbank_rom11). It consumes one power-spectrum frame as a stream of FFT-bin powers and addresses the ROM with the current bin index. It multiplies each power by the returned weight and emits one accumulated filter energy per frame toward the log/DCT stage.

## Interface
- ADDR_WIDTH, 9, bin index width; frame length = 2**ADDR_WIDTH bins; equals ROM address width
- COEF_WIDTH, 8, ROM weight width (unsigned)
- PWR_WIDTH, 32, bin power width (unsigned)
- ACC_WIDTH, 49, result width; default = PWR_WIDTH+COEF_WIDTH+ADDR_WIDTH (overflow-free); smaller values saturate

- clk_tb  in  1  clock, rising edge
- tb_rst  in  1  reset, asynchronous, active-high
- pwr_valid  in  1  power beat valid
- pwr_data  in  PWR_WIDTH  bin power
- pwr_last  in  1  final bin of frame
- pwr_ready  out  1  beat accepted when pwr_valid && pwr_ready
- rom_addr  out  ADDR_WIDTH  ROM address (= bin counter k)
- rom_rd_data  in  COEF_WIDTH  ROM weight; valid one cycle after the edge that samples rom_addr
- mel_valid  out  1  result valid
- mel_data  out  ACC_WIDTH  filter energy
- mel_ready  in  1  result consumed when mel_valid && mel_ready
- frame_err  out  1  sticky: frame length error
- ovf_err  out  1  sticky: accumulator saturated

## Operation
- Reset values: pwr_ready=1, rom_addr=0, mel_valid=0, mel_data=0, frame_err=0, ovf_err=0, acc=0. All pipeline valids are 0. State is RUN.
- States:
  - RUN: pwr_ready=1. An accept with close-of-frame moves to FLUSH.
  - FLUSH: pwr_ready=0. Waits for the closing beat to reach the accumulator; mel_valid is then set and the state moves to HOLD.
  - HOLD: pwr_ready=0. On mel_valid && mel_ready, clear mel_valid and return to RUN.
- rom_addr is driven combinationally from k. The ROM samples it on the accept edge.
- On accept:
  - Stage 1 registers pwr_data, the close flag and valid.
  - k increments, or clears to 0 on close.
- Stage 2 computes product = s1_pwr × rom_rd_data (unsigned, PWR_WIDTH+COEF_WIDTH bits) and registers it with its flags.
- Stage 3 computes sum = acc + product, zero-extended to ACC_WIDTH+1 bits.
  - If sum exceeds 2**ACC_WIDTH−1, clamp to all-ones and set ovf_err.
  - Non-closing beat: acc <= sum.
  - Closing beat: mel_data <= sum, mel_valid <= 1, acc <= 0.
- Close-of-frame conditions:
  - pwr_last=1 at any k.
  - k = 2**ADDR_WIDTH−1 regardless of pwr_last.
- frame_err is set on either of these:
  - pwr_last=1 with k ≠ 2**ADDR_WIDTH−1 (short frame).
  - k = 2**ADDR_WIDTH−1 with pwr_last=0 (long frame; the frame is force-closed and the next beat starts a new frame at k=0).
- Error flags clear only on tb_rst.
- Pipeline never stalls. Backpressure is applied only through pwr_ready, so no in-flight beat can collide with a pending result.
- Reset mid-frame discards the partial sum, k and pending result. The next accepted beat is bin 0.

## Timing
- Accept edge E0 (closing beat) → mel_valid=1 after edge E0+2.
  - Gaps between beats inside a frame do not add latency beyond each beat's own 2 edges.
- pwr_ready falls after E0 and stays low through FLUSH and HOLD. It returns to 1 the cycle after the mel handshake edge.
- mel_data is stable while mel_valid && !mel_ready.
- Throughput: 1 bin/cycle within a frame. Per-frame gap is ≥3 cycles with mel_ready tied high.
- rom_addr changes only on accept edges or reset.
- ROM read latency is exactly 1 cycle (ROM OUT_REG=0). Any other ROM configuration is unsupported.

## Test plan
- Full frame, behavioural 1-cycle ROM with weight[k]=k[7:0], pwr=1 for 512 beats, last on k=511, mel_ready=1 → mel_data=65280, mel_valid 2 cycles after last accept, frame_err=0.
- Weight=2 for all k, pwr=k, pwr_valid toggled randomly → mel_data=261632; rom_addr tracks accepted-beat count exactly.
- Backpressure: mel_ready=0 for 20 cycles after first result → mel_valid/mel_data held, pwr_ready=0 throughout. Handshake, then second frame (weights=1, pwr=3) → mel_data=1536.
- Short frame: pwr_last at k=99, weights=1, pwr=1 → mel_data=100, frame_err=1. The next frame starts at rom_addr=0. Long frame: no last by k=511 → forced close, frame_err=1.
- ACC_WIDTH=16, pwr=0xFFFF, weight=255 → mel_data=0xFFFF, ovf_err=1.
- tb_rst pulse at k=200 mid-frame → all outputs at reset values within the same cycle. The following full frame gives the same result as the first scenario.
